aes_sbox_sched: RTL and testbench

- Sequencer that feeds one shared word of NBYTES masked bytes (e.g. SubWord in key expansion, or a column in the round datapath) through a single pipelined masked AES S-box instance, one byte per cycle.
- Pulls fresh randomness for each S-box call from an external randomness source through a valid/ready handshake.
- Tracks the S-box pipeline, collects the masked results into an output word and presents it with a valid/ready handshake.
- Sits between the round/key controller and the masked S-box.

---
 rtl/aes_sbox_sched.sv | 179 +++++++++++++++++
 tb/tb_aes_sbox_sched.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox_sched
//  Description : Sequencer that streams one word of NBYTES masked bytes
//                through a single pipelined masked AES S-box, one byte per
//                cycle. Each S-box call consumes one fresh randomness word
//                taken through a valid/ready handshake. Results are
//                collected into an output word, which is presented with a
//                valid/ready handshake. Shares are only routed and are never
//                recombined here.
//  Ports       : ClkxCI/RstxRI      - clock, async active-high reset
//                InValidxSI/InReadyxSO/InWordxDI    - input word handshake
//                RndValidxSI/RndReadyxSO/RndxDI     - randomness handshake
//                SboxXxDO/SboxRndxDO/SboxQxDI       - S-box interface
//                OutValidxSO/OutReadyxSI/OutWordxDO - output word handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox_sched #(
    parameter int SHARES     = 2,
    parameter int NBYTES     = 4,
    parameter int SBOX_LAT   = 4,
    parameter int BLIND_NRND = 2,
    localparam int ZM        = 2 * SHARES * (SHARES - 1),
    localparam int ZI        = SHARES * (SHARES - 1),
    localparam int BI        = 2 * BLIND_NRND,
    localparam int RND_W     = 3 * ZM + 3 * ZI + 3 * BI
) (
    input  logic                         ClkxCI,
    input  logic                         RstxRI,
    input  logic                         InValidxSI,
    output logic                         InReadyxSO,
    input  logic [8*SHARES*NBYTES-1:0]   InWordxDI,
    input  logic                         RndValidxSI,
    output logic                         RndReadyxSO,
    input  logic [RND_W-1:0]             RndxDI,
    output logic [8*SHARES-1:0]          SboxXxDO,
    output logic [RND_W-1:0]             SboxRndxDO,
    input  logic [8*SHARES-1:0]          SboxQxDI,
    output logic                         OutValidxSO,
    input  logic                         OutReadyxSI,
    output logic [8*SHARES*NBYTES-1:0]   OutWordxDO
);

    localparam int BW    = 8 * SHARES;
    localparam int WW    = BW * NBYTES;
    localparam int CNT_W = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]          state_q,   state_d;
    logic [WW-1:0]       word_q,    word_d;
    logic [WW-1:0]       out_q,     out_d;
    logic [CNT_W-1:0]    iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]    col_cnt_q, col_cnt_d;
    logic [SBOX_LAT-1:0] vld_q,     vld_d;

    logic                issue_fire;
    logic                capture;
    logic [BW-1:0]       cur_byte;

    // A byte is issued only in a cycle that also consumes a randomness word,
    // so randomness is never reused and never taken without an S-box call.
    assign issue_fire = (state_q == S_ISSUE) && RndValidxSI;

    // The tail of the valid shift register marks the cycle in which the
    // S-box output belongs to a byte issued SBOX_LAT cycles earlier.
    assign capture = ((state_q == S_ISSUE) || (state_q == S_DRAIN))
                     && vld_q[SBOX_LAT-1];

    generate
        if (SBOX_LAT == 1) begin : g_vld_lat1
            assign vld_d = issue_fire;
        end else begin : g_vld_shift
            assign vld_d = {vld_q[SBOX_LAT-2:0], issue_fire};
        end
    endgenerate

    always_comb begin
        cur_byte = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (iss_cnt_q == CNT_W'(b)) begin
                cur_byte = word_q[b*BW +: BW];
            end
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            out_q     <= '0;
            iss_cnt_q <= '0;
            col_cnt_q <= '0;
            vld_q     <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            out_q     <= out_d;
            iss_cnt_q <= iss_cnt_d;
            col_cnt_q <= col_cnt_d;
            vld_q     <= vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        out_d     = out_q;
        iss_cnt_d = iss_cnt_q;
        col_cnt_d = col_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (InValidxSI) begin
                    word_d    = InWordxDI;
                    iss_cnt_d = '0;
                    col_cnt_d = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_fire && (iss_cnt_q == LAST_IDX)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last capture can only happen after the last issue,
                // so completion is only detected here.
                if (capture && (col_cnt_q == LAST_IDX)) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (OutReadyxSI) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue_fire) begin
            iss_cnt_d = iss_cnt_q + CNT_W'(1);
        end

        if (capture) begin
            col_cnt_d = col_cnt_q + CNT_W'(1);
            for (int b = 0; b < NBYTES; b++) begin
                if (col_cnt_q == CNT_W'(b)) begin
                    out_d[b*BW +: BW] = SboxQxDI;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: S-box inputs are forced to zero outside issue cycles so the
    // S-box never sees stale shares or randomness.
    // ------------------------------------------------------------------
    always_comb begin
        InReadyxSO  = (state_q == S_IDLE);
        OutValidxSO = (state_q == S_HOLD);
        RndReadyxSO = issue_fire;
        SboxXxDO    = issue_fire ? cur_byte : '0;
        SboxRndxDO  = issue_fire ? RndxDI   : '0;
        OutWordxDO  = out_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_sbox_sched
//  Description : Self-checking bench for aes_sbox_sched. Emulates a masked
//                S-box with a fixed pipeline latency and checks the block
//                against a transaction-level model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_sched;

    localparam int SHARES     = 2;
    localparam int NBYTES     = 4;
    localparam int SBOX_LAT   = 4;
    localparam int BLIND_NRND = 2;
    localparam int RND_W      = 3 * 2 * SHARES * (SHARES - 1)
                              + 3 * SHARES * (SHARES - 1) + 3 * 2 * BLIND_NRND;
    localparam int BW         = 8 * SHARES;
    localparam int WW         = BW * NBYTES;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_DRAIN = 2;
    localparam int P_HOLD  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              InValidxSI = 1'b0;
    logic              InReadyxSO;
    logic [WW-1:0]     InWordxDI = '0;
    logic              RndValidxSI = 1'b0;
    logic              RndReadyxSO;
    logic [RND_W-1:0]  RndxDI = '0;
    logic [BW-1:0]     SboxXxDO;
    logic [RND_W-1:0]  SboxRndxDO;
    logic [BW-1:0]     SboxQxDI;
    logic              OutValidxSO;
    logic              OutReadyxSI = 1'b0;
    logic [WW-1:0]     OutWordxDO;

    always #5 clk = ~clk;

    aes_sbox_sched #(
        .SHARES     (SHARES),
        .NBYTES     (NBYTES),
        .SBOX_LAT   (SBOX_LAT),
        .BLIND_NRND (BLIND_NRND)
    ) dut (
        .ClkxCI      (clk),
        .RstxRI      (rst),
        .InValidxSI  (InValidxSI),
        .InReadyxSO  (InReadyxSO),
        .InWordxDI   (InWordxDI),
        .RndValidxSI (RndValidxSI),
        .RndReadyxSO (RndReadyxSO),
        .RndxDI      (RndxDI),
        .SboxXxDO    (SboxXxDO),
        .SboxRndxDO  (SboxRndxDO),
        .SboxQxDI    (SboxQxDI),
        .OutValidxSO (OutValidxSO),
        .OutReadyxSI (OutReadyxSI),
        .OutWordxDO  (OutWordxDO)
    );

    // ---------------------------------------------------------------- model
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    // AES S-box from its definition: GF(2^8) inverse then affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] r;
        inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        r = 8'h63;
        for (int k = 0; k < 5; k++) r = r ^ ((inv << k) | (inv >> (8 - k)));
        return r;
    endfunction

    function automatic logic [BW-1:0] mask_byte(input logic [7:0] u);
        logic [BW-1:0] s;
        logic [7:0]    acc;
        s   = '0;
        acc = u;
        for (int i = 1; i < SHARES; i++) begin
            s[i*8 +: 8] = 8'($urandom);
            acc = acc ^ s[i*8 +: 8];
        end
        s[7:0] = acc;
        return s;
    endfunction

    function automatic logic [7:0] unmask_shares(input logic [BW-1:0] v);
        logic [7:0] r;
        r = '0;
        for (int s = 0; s < SHARES; s++) r = r ^ v[s*8 +: 8];
        return r;
    endfunction

    function automatic logic [7:0] unmask_byte(input logic [WW-1:0] w, input int b);
        return unmask_shares(w[b*BW +: BW]);
    endfunction

    // Masked S-box emulator with a fixed SBOX_LAT pipeline and a fresh
    // random share split of every result.
    logic [BW-1:0] pipe [SBOX_LAT];
    always @(posedge clk) begin
        pipe[0] <= mask_byte(aes_sbox(unmask_shares(SboxXxDO)));
        for (int i = 1; i < SBOX_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign SboxQxDI = pipe[SBOX_LAT-1];

    // ------------------------------------------------------------- checking
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expectations set by the stimulus for directed words (-1 / 0 = skip).
    int                   exp_lat    = -1;
    int                   exp_bub    = -1;
    bit                   exp_lit_en = 1'b0;
    logic [8*NBYTES-1:0]  exp_lit    = '0;
    bit                   rnd_inc    = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int               m_phase     = P_IDLE;
    logic [WW-1:0]    m_word      = '0;
    logic [WW-1:0]    m_hold_word = '0;
    logic [WW-1:0]    m_last_out  = '0;
    int               m_issued    = 0;
    int               m_last_iss  = 0;
    int               m_acc_cyc   = 0;
    int               m_bubbles   = 0;
    int               m_pulses    = 0;
    bit               m_hold_first = 1'b0;
    bit               seen_reset  = 1'b0;
    bit               have_prev   = 1'b0;
    logic [RND_W-1:0] prev_rnd    = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                seen_reset = 1'b1;
                chk("rst_sbox_x",    SboxXxDO,    0);
                chk("rst_sbox_rnd",  SboxRndxDO,  0);
                chk("rst_rnd_ready", RndReadyxSO, 0);
                chk("rst_out_valid", OutValidxSO, 0);
                chk("rst_out_word",  OutWordxDO,  0);
                m_phase    = P_IDLE;
                m_last_out = '0;
                have_prev  = 1'b0;
            end else if (seen_reset) begin
                chk("in_ready",  InReadyxSO,  m_phase == P_IDLE);
                chk("out_valid", OutValidxSO, m_phase == P_HOLD);
                chk("rnd_ready", RndReadyxSO, (m_phase == P_ISSUE) && RndValidxSI);
                if (RndReadyxSO) begin
                    if (m_issued < NBYTES) chk("sbox_x", SboxXxDO, m_word[m_issued*BW +: BW]);
                    chk("sbox_rnd", SboxRndxDO, RndxDI);
                    if (have_prev) chk("rnd_reuse", SboxRndxDO != prev_rnd, 1);
                    prev_rnd  = SboxRndxDO;
                    have_prev = 1'b1;
                    m_pulses++;
                end else begin
                    chk("sbox_x_idle",   SboxXxDO,   0);
                    chk("sbox_rnd_idle", SboxRndxDO, 0);
                end
                if (m_phase == P_IDLE) chk("out_word_held", OutWordxDO, m_last_out);
                if (m_phase == P_HOLD) begin
                    if (m_hold_first) begin
                        for (int b = 0; b < NBYTES; b++) begin
                            chk("sbox_result", unmask_byte(OutWordxDO, b),
                                aes_sbox(unmask_byte(m_word, b)));
                            if (exp_lit_en)
                                chk("literal_result", unmask_byte(OutWordxDO, b), exp_lit[b*8 +: 8]);
                        end
                        if (exp_lat >= 0) chk("latency", cyc - m_acc_cyc - 1, exp_lat);
                        if (exp_bub >= 0) chk("bubbles", m_bubbles, exp_bub);
                        chk("rnd_pulses", m_pulses, NBYTES);
                        m_hold_word  = OutWordxDO;
                        m_hold_first = 1'b0;
                    end else begin
                        chk("out_stable", OutWordxDO, m_hold_word);
                    end
                end
                // Advance the model to what the coming clock edge does.
                case (m_phase)
                    P_IDLE: if (InValidxSI) begin
                        m_word    = InWordxDI;
                        m_issued  = 0;
                        m_acc_cyc = cyc;
                        m_bubbles = 0;
                        m_pulses  = 0;
                        m_phase   = P_ISSUE;
                    end
                    P_ISSUE: if (RndValidxSI) begin
                        m_last_iss = cyc;
                        m_issued++;
                        if (m_issued == NBYTES) m_phase = P_DRAIN;
                    end else begin
                        m_bubbles++;
                    end
                    P_DRAIN: if (cyc == m_last_iss + SBOX_LAT) begin
                        m_phase      = P_HOLD;
                        m_hold_first = 1'b1;
                    end
                    default: if (OutReadyxSI) begin
                        m_phase    = P_IDLE;
                        m_last_out = m_hold_word;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string what);
        $display("FAIL timeout_%s: got no progress expected progress", what);
        $fatal(1, "bench stopped");
    endtask

    task automatic next_rnd();
        RndxDI = rnd_inc ? RndxDI + RND_W'(1) : RND_W'($urandom);
    endtask

    task automatic accept_word(input logic [8*NBYTES-1:0] u);
        bit done;
        int n;
        for (int b = 0; b < NBYTES; b++) InWordxDI[b*BW +: BW] = mask_byte(u[b*8 +: 8]);
        InValidxSI = 1'b1;
        done = 1'b0;
        n    = 0;
        while (!done) begin
            @(negedge clk);
            done = InReadyxSO;
            tick();
            n++;
            if (!done && n > 100) timeout("accept");
        end
        InValidxSI = 1'b0;
        InWordxDI  = {WW/32{$urandom}};
    endtask

    task automatic run_word(input logic [8*NBYTES-1:0] u, input int stall_at,
                            input int stall_len, input int hold_cyc, input bit rand_rv);
        int  issued;
        int  left;
        int  n;
        bit  consumed;
        bit  done;
        accept_word(u);
        issued = 0;
        left   = stall_len;
        n      = 0;
        while (issued < NBYTES) begin
            if (issued == stall_at && left > 0) begin
                RndValidxSI = 1'b0;
                left--;
            end else begin
                RndValidxSI = rand_rv ? ($urandom_range(3) != 0) : 1'b1;
            end
            @(negedge clk);
            consumed = RndValidxSI && RndReadyxSO;
            tick();
            if (consumed) begin
                issued++;
                next_rnd();
            end
            n++;
            if (n > 200) timeout("issue");
        end
        // Offer randomness outside issue cycles; it must not be taken.
        RndValidxSI = rand_rv ? 1'($urandom_range(1)) : 1'b0;
        left        = hold_cyc;
        OutReadyxSI = (left == 0);
        done        = 1'b0;
        n           = 0;
        while (!done) begin
            @(negedge clk);
            if (OutValidxSO && OutReadyxSI) done = 1'b1;
            else if (OutValidxSO) left--;
            tick();
            OutReadyxSI = (left <= 0) && !done;
            n++;
            if (!done && n > 200) timeout("output");
        end
        RndValidxSI = 1'b0;
    endtask

    task automatic reset_mid_issue();
        int issued;
        int n;
        bit consumed;
        accept_word(32'($urandom));
        RndValidxSI = 1'b1;
        issued = 0;
        n      = 0;
        while (issued < 2) begin
            @(negedge clk);
            consumed = RndValidxSI && RndReadyxSO;
            tick();
            if (consumed) begin
                issued++;
                next_rnd();
            end
            n++;
            if (n > 50) timeout("partial_issue");
        end
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        RndValidxSI = 1'b0;
    endtask

    initial begin
        // Reset asserted between edges for three cycles.
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) tick();

        // Directed word, randomness always valid.
        exp_lit    = 32'h16ED7C63;
        exp_lit_en = 1'b1;
        exp_lat    = 8;
        exp_bub    = 0;
        run_word(32'hFF530100, -1, 0, 0, 1'b0);
        tick();

        // Two randomness bubbles before byte 2.
        exp_lat = 10;
        exp_bub = 2;
        run_word(32'hFF530100, 2, 2, 0, 1'b0);

        // Output backpressure for five cycles.
        exp_lit_en = 1'b0;
        exp_lat    = 8;
        exp_bub    = 0;
        run_word(32'($urandom), -1, 0, 5, 1'b0);

        // Reset in the middle of issuing, then a fresh word.
        exp_lat = -1;
        exp_bub = -1;
        reset_mid_issue();
        exp_lit    = 32'h0904B7CA;
        exp_lit_en = 1'b1;
        exp_lat    = 8;
        exp_bub    = 0;
        run_word(32'h40302010, -1, 0, 0, 1'b0);

        // Randomized traffic with random randomness availability.
        exp_lit_en = 1'b0;
        exp_lat    = -1;
        exp_bub    = -1;
        rnd_inc    = 1'b0;
        for (int t = 0; t < 20; t++) begin
            run_word(32'($urandom), $urandom_range(NBYTES - 1), $urandom_range(3),
                     $urandom_range(4), 1'b1);
            repeat ($urandom_range(2)) tick();
        end

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
